// File: rtl/seg_scan_display_if.sv
// +----------------------------------------------------------------------+
// | seg_scan_display_if : BCD time in, multiplexed 7-segment drive out   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface seg_scan_display_if;
  logic       EN;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       lz_blank;
  logic [2:0] blink_sel;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output EN, hour, minute, second, lz_blank, blink_sel,
    input  an, seg, dp
  );

  modport slave (
    input  EN, hour, minute, second, lz_blank, blink_sel,
    output an, seg, dp
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_display.sv
// +----------------------------------------------------------------------+
// | seg_scan_display : six-digit multiplexed common-anode scanner        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 83
) (
  input  logic             CP,
  input  logic             CLR,
  seg_scan_display_if.slave bus
);

  localparam int            c_pw        = $clog2(SCAN_DIV);
  localparam int            c_fw        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_pw-1:0] c_pc_max  = c_pw'(SCAN_DIV - 1);
  localparam logic [c_fw-1:0] c_fc_max  = c_fw'(BLINK_DIV - 1);
  localparam logic [2:0]    c_last_slot = 3'd5;

  logic [c_pw-1:0] r_pc;
  logic [2:0]      r_idx;
  logic [23:0]     r_snap;
  logic [c_fw-1:0] r_fcnt;
  logic            r_phase;
  logic [5:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_tick;
  logic            w_frame;
  logic [2:0]      w_idx_nxt;
  logic            w_phase_nxt;
  logic [23:0]     w_src;
  logic [3:0]      w_nib;
  logic            w_grp;
  logic            w_blank;
  logic            w_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    w_tick      = bus.EN && (r_pc == c_pc_max);
    w_frame     = w_tick && (r_idx == c_last_slot);
    w_idx_nxt   = (r_idx == c_last_slot) ? 3'd0 : r_idx + 3'd1;
    // Blanking uses the phase in force after this edge so a frame is uniform.
    w_phase_nxt = r_phase ^ (w_frame && (r_fcnt == c_fc_max));
    // Slot 0 is shown on the capture edge itself, before the snapshot lands.
    w_src       = w_frame ? {bus.hour, bus.minute, bus.second} : r_snap;

    case (w_idx_nxt)
      3'd0:    w_nib = w_src[3:0];
      3'd1:    w_nib = w_src[7:4];
      3'd2:    w_nib = w_src[11:8];
      3'd3:    w_nib = w_src[15:12];
      3'd4:    w_nib = w_src[19:16];
      default: w_nib = w_src[23:20];
    endcase

    case (w_idx_nxt)
      3'd0, 3'd1: w_grp = bus.blink_sel[0];
      3'd2, 3'd3: w_grp = bus.blink_sel[1];
      default:    w_grp = bus.blink_sel[2];
    endcase

    w_blank = ((w_idx_nxt == c_last_slot) && bus.lz_blank && (w_nib == 4'd0))
              || (w_grp && w_phase_nxt);
    w_dp    = ~(~w_blank && ((w_idx_nxt == 3'd2) || (w_idx_nxt == 3'd4)) && ~r_snap[0]);
  end

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      r_pc    <= '0;
      r_idx   <= c_last_slot;
      r_snap  <= '0;
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_pc  <= '0;
      r_idx <= w_idx_nxt;
      if (w_frame) begin
        r_snap  <= {bus.hour, bus.minute, bus.second};
        r_fcnt  <= (r_fcnt == c_fc_max) ? '0 : r_fcnt + c_fw'(1);
        r_phase <= w_phase_nxt;
      end
    end else if (bus.EN) begin
      r_pc <= r_pc + c_pw'(1);
    end
  end

  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      r_an  <= 6'h3F;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      r_an  <= w_blank ? 6'h3F : ~(6'd1 << w_idx_nxt);
      r_seg <= w_blank ? 7'h7F : seg_decode(w_nib);
      r_dp  <= w_dp;
    end else if (!bus.EN) begin
      r_an  <= 6'h3F;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_display.sv
// +----------------------------------------------------------------------+
// | tb_seg_scan_display : directed bench for seg_scan_display            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;
  localparam int NV        = 7;

  logic CP  = 1'b0;
  logic CLR = 1'b1;

  seg_scan_display_if bus ();

  seg_scan_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .CP  (CP),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic [7:0]      h;
    logic [7:0]      m;
    logic [7:0]      s;
    logic            lz;
    logic [5:0][6:0] seg;   // expected seg per slot, 1111111 = blanked
    logic [5:0]      dp;    // expected dp per slot
  } vec_t;

  vec_t vt [NV];
  int   n_tests;
  int   n_fail;
  int   slot;
  int   frames;

  function automatic vec_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic lz, input logic [6:0] s5, input logic [6:0] s4,
                              input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                              input logic [6:0] s0, input logic [5:0] dp);
    vec_t v;
    v.h = h; v.m = m; v.s = s; v.lz = lz;
    v.seg = {s5, s4, s3, s2, s1, s0};
    v.dp  = dp;
    return v;
  endfunction

  function automatic logic [5:0] exp_an(input int k, input logic [6:0] s);
    return (s == 7'h7F) ? 6'h3F : ~(6'b000001 << k);
  endfunction

  task automatic check(input string name, input logic [5:0] ea, input logic [6:0] es,
                       input logic ed);
    n_tests++;
    if (bus.an !== ea || bus.seg !== es || bus.dp !== ed) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, bus.an, bus.seg, bus.dp, ea, es, ed);
    end
  endtask

  task automatic check_off(input string name);
    check(name, 6'h3F, 7'h7F, 1'b1);
  endtask

  task automatic check_slot(input string name, input vec_t v, input int k);
    check(name, exp_an(k, v.seg[k]), v.seg[k], v.dp[k]);
  endtask

  task automatic apply(input vec_t v);
    bus.hour     = v.h;
    bus.minute   = v.m;
    bus.second   = v.s;
    bus.lz_blank = v.lz;
  endtask

  // Called at the falling edge right after a slot's tick; moves to the next slot.
  task automatic advance_slot();
    repeat (SCAN_DIV) @(negedge CP);
    slot = (slot == 5) ? 0 : slot + 1;
    if (slot == 0) frames++;
  endtask

  task automatic goto_slot(input int t);
    for (int i = 0; i < 6 && slot != t; i++) advance_slot();
  endtask

  // Releases reset at a falling edge and walks the first frame edge by edge.
  task automatic run_from_reset(input string tag);
    CLR = 1'b0;
    for (int e = 1; e <= SCAN_DIV - 1; e++) begin
      @(negedge CP);
      check_off($sformatf("%s pre-tick edge %0d", tag, e));
    end
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        @(negedge CP);
        check_slot($sformatf("%s slot %0d cyc %0d", tag, k, c), vt[0], k);
      end
    end
    @(negedge CP);
    slot   = 0;
    frames = 2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic phase;
    logic blanked;
    logic [6:0] es;

    n_tests = 0; n_fail = 0; slot = 5; frames = 0;

    vt[0] = mk(8'h12, 8'h34, 8'h56, 1'b0, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 6'b101011);
    vt[1] = mk(8'h09, 8'h00, 8'h00, 1'b1, 7'b1111111, 7'b0010000, 7'b1000000,
               7'b1000000, 7'b1000000, 7'b1000000, 6'b101011);
    vt[2] = mk(8'h09, 8'h00, 8'h00, 1'b0, 7'b1000000, 7'b0010000, 7'b1000000,
               7'b1000000, 7'b1000000, 7'b1000000, 6'b101011);
    vt[3] = mk(8'h00, 8'h00, 8'h5A, 1'b0, 7'b1000000, 7'b1000000, 7'b1000000,
               7'b1000000, 7'b0010010, 7'b0111111, 6'b101011);
    vt[4] = mk(8'h23, 8'h07, 8'h58, 1'b0, 7'b0100100, 7'b0110000, 7'b1000000,
               7'b1111000, 7'b0010010, 7'b0000000, 6'b101011);
    vt[5] = mk(8'h1B, 8'hF9, 8'h57, 1'b0, 7'b1111001, 7'b0111111, 7'b0111111,
               7'b0010000, 7'b0010010, 7'b1111000, 6'b111111);
    vt[6] = mk(8'h10, 8'h86, 8'h42, 1'b1, 7'b1111001, 7'b1000000, 7'b0000000,
               7'b0000010, 7'b0011001, 7'b0100100, 6'b101011);

    apply(vt[0]);
    bus.blink_sel = 3'b000;
    bus.EN        = 1'b1;

    // Power-on reset and first frame
    #12;
    check_off("reset outputs");
    @(negedge CP);
    run_from_reset("first frame");

    // Table vectors: inputs land before a frame start, whole frame checked
    for (int i = 0; i < NV; i++) begin
      goto_slot(5);
      apply(vt[i]);
      for (int k = 0; k < 6; k++) begin
        advance_slot();
        check_slot($sformatf("vec %0d slot %0d", i, k), vt[i], k);
      end
    end

    // Mid-frame minute change is deferred to the next frame
    goto_slot(5);
    apply(vt[0]);
    advance_slot();
    advance_slot();
    bus.minute = 8'h59;
    advance_slot();
    check("snap old min units", 6'b111011, 7'b0011001, 1'b0);
    advance_slot();
    check("snap old min tens", 6'b110111, 7'b0110000, 1'b1);
    goto_slot(1);
    advance_slot();
    check("snap new min units", 6'b111011, 7'b0010000, 1'b0);
    advance_slot();
    check("snap new min tens", 6'b110111, 7'b0010010, 1'b1);

    // Hour blink over six frames
    goto_slot(5);
    apply(vt[0]);
    bus.blink_sel = 3'b100;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 6; k++) begin
        advance_slot();
        phase   = ((frames / BLINK_DIV) % 2) == 1;
        blanked = (k >= 4) && phase;
        es      = blanked ? 7'h7F : vt[0].seg[k];
        check($sformatf("blink frame %0d slot %0d", frames, k), exp_an(k, es), es,
              blanked ? 1'b1 : vt[0].dp[k]);
      end
    end
    bus.blink_sel = 3'b000;

    // Scan enable drop at slot 3 with pc held at 2
    goto_slot(3);
    repeat (2) @(negedge CP);
    bus.EN = 1'b0;
    @(negedge CP);
    check_off("en low next edge");
    repeat (9) @(negedge CP);
    check_off("en low held");
    bus.EN = 1'b1;
    @(negedge CP);
    check_off("en resume before tick");
    @(negedge CP);
    check_slot("en resume slot 4", vt[0], 4);
    slot = 4;

    // Asynchronous reset mid-slot, then a clean restart
    advance_slot();
    @(negedge CP);
    #2 CLR = 1'b1;
    #1 check_off("clr async mid-slot");
    @(negedge CP);
    check_off("clr held");
    @(negedge CP);
    run_from_reset("after clr");

    // Blink phase restarts from zero: frame 2 after reset blanks hours
    bus.blink_sel = 3'b100;
    for (int k = 1; k < 6; k++) begin
      advance_slot();
      es = (k >= 4) ? 7'h7F : vt[0].seg[k];
      check($sformatf("post-clr blink slot %0d", k), exp_an(k, es), es,
            (k >= 4) ? 1'b1 : vt[0].dp[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
